// File: rtl/stream_merge_pkg.sv
// Shared types and default sizing for the round-robin stream merger.
package stream_merge_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DFLT_NUM_PORTS = 8;
  localparam int DFLT_DATA_W    = 64;
  localparam int DFLT_BURST_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int j;
    j   = 0;
    idx = ptr;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_merge.sv
// N-to-1 AXI-Stream merger with round-robin burst grants and a registered output stage.
module stream_rr_merge
  import stream_merge_pkg::*;
#(
  parameter  int NUM_PORTS = DFLT_NUM_PORTS,
  parameter  int DATA_W    = DFLT_DATA_W,
  parameter  int BURST_MAX = DFLT_BURST_MAX,
  localparam int IDX_W     = $clog2(NUM_PORTS),
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [NUM_PORTS*DATA_W-1:0] s_TDATA,
  input  logic [NUM_PORTS-1:0]        s_TVALID,
  output logic [NUM_PORTS-1:0]        s_TREADY,
  output logic [DATA_W-1:0]           m_TDATA,
  output logic [IDX_W-1:0]            m_TDEST,
  output logic                        m_TLAST,
  output logic                        m_TVALID,
  input  logic                        m_TREADY
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [IDX_W-1:0]  m_dest_q, m_dest_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              gnt_valid, gnt_ready, accept, last_beat;
  logic [IDX_W-1:0]  gnt_next;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req (s_TVALID),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Ready is masked during reset so no handshake can complete in a reset cycle.
  assign gnt_valid = s_TVALID[gnt_q];
  assign gnt_ready = (state_q == GRANT) && !ap_rst && (!m_valid_q || m_TREADY);
  assign accept    = gnt_valid && gnt_ready;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST_MAX - 1));
  assign gnt_next  = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + IDX_W'(1);

  always_comb begin
    s_TREADY        = '0;
    s_TREADY[gnt_q] = gnt_ready;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    m_data_d   = m_data_q;
    m_dest_d   = m_dest_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;

    if (accept) begin
      m_data_d   = s_TDATA[gnt_q*DATA_W +: DATA_W];
      m_dest_d   = gnt_q;
      m_last_d   = last_beat;
      m_valid_d  = 1'b1;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end else if (m_TREADY) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Leave on a full burst or when the granted port goes quiet while we could take data.
        if ((accept && last_beat) || (gnt_ready && !gnt_valid)) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_dest_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      m_data_q   <= m_data_d;
      m_dest_q   <= m_dest_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_TDATA  = m_data_q;
  assign m_TDEST  = m_dest_q;
  assign m_TLAST  = m_last_q;
  assign m_TVALID = m_valid_q;

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed scoreboard bench for stream_rr_merge with default parameters.
module tb_stream_rr_merge;

  localparam int NP = 8;
  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    dest;
    logic          last;
  } beat_t;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic [NP*DW-1:0]   s_TDATA = '0;
  logic [NP-1:0]      s_TVALID = '0;
  logic [NP-1:0]      s_TREADY;
  logic [DW-1:0]      m_TDATA;
  logic [2:0]         m_TDEST;
  logic               m_TLAST;
  logic               m_TVALID;
  logic               m_TREADY = 1'b1;

  stream_rr_merge dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .s_TDATA  (s_TDATA),
    .s_TVALID (s_TVALID),
    .s_TREADY (s_TREADY),
    .m_TDATA  (m_TDATA),
    .m_TDEST  (m_TDEST),
    .m_TLAST  (m_TLAST),
    .m_TVALID (m_TVALID),
    .m_TREADY (m_TREADY)
  );

  always #5 ap_clk = ~ap_clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cnt [NP];
  logic [DW-1:0] src [NP][$];
  beat_t         exp_q [$];
  logic [NP-1:0] acc;
  bit            bp_en = 1'b0;
  logic [3:0]    bp_pat = 4'b1001;
  int            pops = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc = 0;
  bit            stall_q = 1'b0;
  beat_t         held;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Source model: handshake sampled at the edge, queues advanced just after it.
  initial for (int i = 0; i < NP; i++) acc_cnt[i] = 0;
  always @(posedge ap_clk) begin
    cyc++;
    acc = s_TVALID & s_TREADY & {NP{~ap_rst}};
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i] && src[i].size() > 0) begin
        void'(src[i].pop_front());
        acc_cnt[i]++;
      end
      s_TVALID[i] = (src[i].size() > 0);
      s_TDATA[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : '0;
    end
    m_TREADY = bp_en ? bp_pat[cyc % 4] : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge ap_clk) begin
    beat_t got;
    beat_t want;
    if (ap_rst) begin
      stall_q = 1'b0;
    end else begin
      got = '{d: m_TDATA, dest: m_TDEST, last: m_TLAST};
      chk($onehot0(s_TREADY), "tready_onehot", 128'(s_TREADY), 128'(0));
      if (stall_q)
        chk(m_TVALID && (got == held), "hold_stable", 128'(got), 128'(held));
      if (m_TVALID && !m_TREADY)
        chk(s_TREADY == '0, "stall_tready_low", 128'(s_TREADY), 128'(0));
      if (m_TVALID && m_TREADY) begin
        chk(exp_q.size() != 0, "unexpected_beat", 128'(got), 128'(0));
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk(got == want, "beat", 128'(got), 128'(want));
        end
        if (pops == 0) first_pop_cyc = cyc;
        pops++;
        last_pop_cyc = cyc;
      end
      stall_q = m_TVALID && !m_TREADY;
      held    = got;
    end
  end

  task automatic add_exp(input logic [DW-1:0] d, input int dest, input bit last);
    exp_q.push_back('{d: d, dest: 3'(dest), last: last});
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge ap_clk);
      done = (exp_q.size() == 0) && !m_TVALID && (s_TVALID == '0);
    end
    chk(done, {name, "_drain"}, 128'(exp_q.size()), 128'(0));
    repeat (3) @(negedge ap_clk);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    bit seen;

    // Reset state
    repeat (3) @(negedge ap_clk);
    chk(m_TVALID == 1'b0, "rst_m_tvalid", 128'(m_TVALID), 128'(0));
    chk(s_TREADY == '0,   "rst_s_tready", 128'(s_TREADY), 128'(0));
    chk(m_TDATA == '0,    "rst_m_tdata",  128'(m_TDATA),  128'(0));
    chk(m_TDEST == '0,    "rst_m_tdest",  128'(m_TDEST),  128'(0));
    chk(m_TLAST == 1'b0,  "rst_m_tlast",  128'(m_TLAST),  128'(0));
    ap_rst = 1'b0;
    repeat (2) @(negedge ap_clk);

    // Single port p3, 5 beats, latency of 2 cycles
    for (int k = 0; k < 5; k++) begin
      src[3].push_back(64'h30 + 64'(k));
      add_exp(64'h30 + 64'(k), 3, 1'b0);
    end
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge ap_clk);
      seen = s_TVALID[3];
    end
    n = 0;
    while (!m_TVALID && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    chk(n == 2, "p3_latency", 128'(n), 128'(2));
    wait_drain("p3", 100);
    chk(dut.rr_ptr_q == 3'd4, "p3_rr_ptr", 128'(dut.rr_ptr_q), 128'(4));

    // Wrap-around: move pointer to 7 with a lone p6 beat, then p0 and p6 compete
    src[6].push_back(64'h66);
    add_exp(64'h66, 6, 1'b0);
    wait_drain("p6_single", 100);
    chk(dut.rr_ptr_q == 3'd7, "wrap_rr_ptr", 128'(dut.rr_ptr_q), 128'(7));
    src[0].push_back(64'hA0);
    src[0].push_back(64'hA1);
    src[6].push_back(64'h60);
    src[6].push_back(64'h61);
    add_exp(64'hA0, 0, 1'b0);
    add_exp(64'hA1, 0, 1'b0);
    add_exp(64'h60, 6, 1'b0);
    add_exp(64'h61, 6, 1'b0);
    wait_drain("wrap", 100);

    // Early release: p2 sends 3 beats while p5 waits (pointer now 7)
    for (int k = 0; k < 3; k++) begin
      src[2].push_back(64'h20 + 64'(k));
      add_exp(64'h20 + 64'(k), 2, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      src[5].push_back(64'h50 + 64'(k));
      add_exp(64'h50 + 64'(k), 5, 1'b0);
    end
    wait_drain("early_release", 100);

    // Backpressure on a full p0 burst
    bp_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      src[0].push_back(64'h100 + 64'(k));
      add_exp(64'h100 + 64'(k), 0, k == 15);
    end
    wait_drain("backpressure", 200);
    bp_en = 1'b0;
    repeat (2) @(negedge ap_clk);

    // Reset mid-burst on p1: beats 1..6 delivered, beat 7 discarded by reset
    base = acc_cnt[1];
    for (int k = 0; k < 16; k++) src[1].push_back(64'h10 + 64'(k));
    for (int k = 0; k < 6; k++) add_exp(64'h10 + 64'(k), 1, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(posedge ap_clk);
      #2;
      seen = (acc_cnt[1] - base == 7);
    end
    chk(seen, "rst_mid_reach_beat7", 128'(acc_cnt[1] - base), 128'(7));
    ap_rst = 1'b1;
    src[1].delete();
    @(posedge ap_clk);
    #2;
    chk(m_TVALID == 1'b0, "rst_mid_m_tvalid", 128'(m_TVALID), 128'(0));
    chk(s_TREADY == '0,   "rst_mid_s_tready", 128'(s_TREADY), 128'(0));
    chk(exp_q.size() == 0, "rst_mid_delivered", 128'(exp_q.size()), 128'(0));
    ap_rst = 1'b0;
    @(negedge ap_clk);
    src[0].push_back(64'hB0);
    src[5].push_back(64'hB5);
    add_exp(64'hB0, 0, 1'b0);
    add_exp(64'hB5, 5, 1'b0);
    wait_drain("rst_restart", 100);

    // All ports valid: grants 0..7 then 0 again, one bubble between grants
    do_reset();
    @(negedge ap_clk);
    pops = 0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < ((p == 0) ? 32 : 16); k++)
        src[p].push_back(64'(p) * 64'h1000 + 64'(k));
    end
    for (int g = 0; g < 9; g++) begin
      for (int k = 0; k < 16; k++)
        add_exp(64'(g % NP) * 64'h1000 + 64'((g == 8) ? 16 + k : k), g % NP, k == 15);
    end
    wait_drain("all_ports", 400);
    chk(pops == 144, "all_ports_beats", 128'(pops), 128'(144));
    chk(last_pop_cyc - first_pop_cyc + 1 == 152, "all_ports_span",
        128'(last_pop_cyc - first_pop_cyc + 1), 128'(152));

    chk(exp_q.size() == 0, "final_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
